// File: rtl/filter_mac_accumulator.sv
// Serial FIR MAC: one tap per cycle over a NUM_TAPS delay line.
// Ports: clk/rst, sample handshake, coef write, delay clear, acc_out/acc_valid/busy.
module filter_mac_accumulator #(
  parameter int NUM_TAPS = 8,
  parameter int TAP_AW   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic              coef_wr_en,
  input  logic [TAP_AW-1:0] coef_addr,
  input  logic [15:0]       coef_wdata,
  input  logic              trig_delay_clear,
  output logic [39:0]       acc_out,
  output logic              acc_valid,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [TAP_AW-1:0] tap_q, tap_d;
  logic [39:0] acc_q, acc_d;
  logic [39:0] acc_out_q, acc_out_d;

  logic signed [15:0] x_q [NUM_TAPS];
  logic signed [15:0] x_d [NUM_TAPS];
  logic signed [15:0] c_q [NUM_TAPS];
  logic signed [15:0] c_d [NUM_TAPS];

  logic signed [31:0] prod;
  logic [39:0] acc_sum;
  logic addr_ok;

  assign prod    = c_q[tap_q] * x_q[tap_q];
  assign acc_sum = acc_q + {{8{prod[31]}}, prod};
  assign addr_ok = int'(coef_addr) < NUM_TAPS;

  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    acc_d     = acc_q;
    acc_out_d = acc_out_q;
    x_d       = x_q;
    c_d       = c_q;

    if (coef_wr_en && addr_ok) begin
      c_d[coef_addr] = coef_wdata;
    end

    unique case (state_q)
      IDLE: begin
        if (trig_delay_clear) begin
          for (int k = 0; k < NUM_TAPS; k++) begin
            x_d[k] = '0;
          end
        end
        if (sample_valid) begin
          // clear beats the shift; x[0] still loads
          for (int k = 1; k < NUM_TAPS; k++) begin
            x_d[k] = trig_delay_clear ? '0 : x_q[k-1];
          end
          x_d[0]  = sample_in;
          acc_d   = '0;
          tap_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_sum;
        tap_d = tap_q + 1'b1;
        if (tap_q == TAP_AW'(NUM_TAPS - 1)) begin
          // publish only the final sum
          acc_out_d = acc_sum;
          tap_d     = '0;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tap_q     <= '0;
      acc_q     <= '0;
      acc_out_q <= '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        x_q[k] <= '0;
        c_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      acc_q     <= acc_d;
      acc_out_q <= acc_out_d;
      x_q       <= x_d;
      c_q       <= c_d;
    end
  end

  assign sample_ready = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign acc_valid    = (state_q == DONE);
  assign acc_out      = acc_out_q;

endmodule

// File: tb/tb_filter_mac_accumulator.sv
// Directed self-checking bench for filter_mac_accumulator.
// Table-driven passes plus hand sequences for handshake, mid-pass and reset cases.
module tb_filter_mac_accumulator;

  localparam int NT = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   sample_in;
  logic          sample_valid;
  logic          sample_ready;
  logic          coef_wr_en;
  logic [AW-1:0] coef_addr;
  logic [15:0]   coef_wdata;
  logic          trig_delay_clear;
  logic [39:0]   acc_out;
  logic          acc_valid;
  logic          busy;

  filter_mac_accumulator #(
    .NUM_TAPS(NT),
    .TAP_AW  (AW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .sample_in       (sample_in),
    .sample_valid    (sample_valid),
    .sample_ready    (sample_ready),
    .coef_wr_en      (coef_wr_en),
    .coef_addr       (coef_addr),
    .coef_wdata      (coef_wdata),
    .trig_delay_clear(trig_delay_clear),
    .acc_out         (acc_out),
    .acc_valid       (acc_valid),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] s;
    logic [39:0] exp;
  } vec_t;

  vec_t        tbl [12];
  int          checks = 0;
  int          failures = 0;
  logic [39:0] prev_out = '0;

  task automatic chk(input string name, input logic [39:0] act,
                     input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_coef(input int a, input logic [15:0] d);
    coef_wr_en = 1'b1;
    coef_addr  = AW'(a);
    coef_wdata = d;
    tick();
    coef_wr_en = 1'b0;
  endtask

  task automatic all_coef(input logic [15:0] d);
    for (int k = 0; k < NT; k++) wr_coef(k, d);
  endtask

  task automatic pulse_clear();
    trig_delay_clear = 1'b1;
    tick();
    trig_delay_clear = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    prev_out = '0;
  endtask

  task automatic accept_sample(input logic [15:0] s, input logic clr);
    int n;
    n = 0;
    while (!sample_ready && n < 20) begin
      tick();
      n++;
    end
    if (!sample_ready) chk("ready_timeout", 40'(sample_ready), 40'd1);
    sample_in        = s;
    sample_valid     = 1'b1;
    trig_delay_clear = clr;
    tick();
    sample_valid     = 1'b0;
    trig_delay_clear = 1'b0;
  endtask

  task automatic run_pass(input logic [15:0] s, input logic clr,
                          input logic [39:0] exp, input string name);
    int bad;
    bad = 0;
    accept_sample(s, clr);
    for (int i = 1; i <= NT; i++) begin
      tick();
      if (i < NT && (acc_valid || acc_out !== prev_out || !busy)) bad++;
    end
    chk({name, " partial"}, 40'(bad), 40'd0);
    chk({name, " valid"}, 40'(acc_valid), 40'd1);
    chk(name, acc_out, exp);
    tick();
    chk({name, " pulse_end"}, 40'(acc_valid), 40'd0);
    chk({name, " ready"}, 40'(sample_ready), 40'd1);
    prev_out = exp;
  endtask

  initial begin
    int          mx [NT];
    logic [39:0] expq [$];
    logic [39:0] e;
    logic [39:0] sum;
    int          accepts, results, bad_int, bad_rdy, last, nxt, cnt;
    logic        rdy;

    rst = 1'b1;
    sample_in = '0;
    sample_valid = 1'b0;
    coef_wr_en = 1'b0;
    coef_addr = '0;
    coef_wdata = '0;
    trig_delay_clear = 1'b0;

    for (int i = 0; i < 8; i++) tbl[i] = '{16'h0000, 40'(i + 1)};
    tbl[0]  = '{16'h0001, 40'd1};
    tbl[8]  = '{16'h0005, 40'd5};
    tbl[9]  = '{16'hFFFE, 40'd8};
    tbl[10] = '{16'h0003, 40'd14};
    tbl[11] = '{16'h8000, 40'hFFFFFF8014};

    do_reset();
    chk("rst ready", 40'(sample_ready), 40'd1);
    chk("rst busy", 40'(busy), 40'd0);
    chk("rst valid", 40'(acc_valid), 40'd0);
    chk("rst acc_out", acc_out, 40'd0);

    // impulse and mixed-sign vectors, c[k] = k+1
    for (int k = 0; k < NT; k++) wr_coef(k, 16'(k + 1));
    for (int i = 0; i < 12; i++) begin
      run_pass(tbl[i].s, 1'b0, tbl[i].exp, $sformatf("vec%0d", i));
    end

    // signed extremes
    do_reset();
    all_coef(16'h8000);
    for (int i = 0; i < NT; i++) begin
      e = 40'(i + 1) << 30;
      run_pass(16'h8000, 1'b0, e, $sformatf("min_min%0d", i));
    end
    pulse_clear();
    run_pass(16'h8000, 1'b0, 40'h0040000000, "clear_keeps_coef");
    pulse_clear();
    all_coef(16'h7FFF);
    for (int i = 0; i < NT; i++) begin
      e = 40'd0 - 40'(i + 1) * 40'h003FFF8000;
      run_pass(16'h8000, 1'b0, e, $sformatf("max_min%0d", i));
    end

    // valid held high continuously
    do_reset();
    all_coef(16'h0001);
    for (int k = 0; k < NT; k++) mx[k] = 0;
    accepts = 0;
    results = 0;
    bad_int = 0;
    bad_rdy = 0;
    last = -1;
    nxt = 1;
    sample_in = 16'(nxt);
    sample_valid = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      rdy = sample_ready;
      if (rdy == busy) bad_rdy++;
      tick();
      if (rdy) begin
        if (last >= 0 && cyc - last != 10) bad_int++;
        last = cyc;
        accepts++;
        for (int k = NT - 1; k > 0; k--) mx[k] = mx[k-1];
        mx[0] = nxt;
        sum = '0;
        for (int k = 0; k < NT; k++) sum = sum + 40'(mx[k]);
        expq.push_back(sum);
        nxt++;
        sample_in = 16'(nxt);
      end
      if (acc_valid) begin
        results++;
        if (expq.size() == 0) chk("hs extra result", acc_out, 40'd0 - 40'd1);
        else chk($sformatf("hs result%0d", results), acc_out, expq.pop_front());
      end
    end
    sample_valid = 1'b0;
    chk("hs accepts", 40'(accepts), 40'd4);
    chk("hs results", 40'(results), 40'd4);
    chk("hs interval", 40'(bad_int), 40'd0);
    chk("hs ready_vs_busy", 40'(bad_rdy), 40'd0);
    prev_out = 40'd10;

    // mid-pass coef write and ignored clear
    pulse_clear();
    for (int i = 0; i < NT; i++) begin
      run_pass(16'h0001, 1'b0, 40'(i + 1), $sformatf("ones%0d", i));
    end
    accept_sample(16'h0001, 1'b0);
    for (int i = 1; i <= NT; i++) begin
      tick();
      if (i == 2) begin
        coef_wr_en       = 1'b1;
        coef_addr        = 3'd7;
        coef_wdata       = 16'd10;
        trig_delay_clear = 1'b1;
      end
      if (i == 3) begin
        coef_wr_en       = 1'b0;
        trig_delay_clear = 1'b0;
      end
    end
    chk("midpass valid", 40'(acc_valid), 40'd1);
    chk("midpass acc", acc_out, 40'd17);
    tick();
    prev_out = 40'd17;
    run_pass(16'h0001, 1'b0, 40'd17, "midpass_clear_ignored");

    // reset mid-MAC, colliding with accept, write and clear
    accept_sample(16'h0001, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    coef_wr_en = 1'b1;
    coef_addr = 3'd0;
    coef_wdata = 16'd5;
    sample_valid = 1'b1;
    sample_in = 16'h0001;
    trig_delay_clear = 1'b1;
    tick();
    rst = 1'b0;
    coef_wr_en = 1'b0;
    sample_valid = 1'b0;
    trig_delay_clear = 1'b0;
    prev_out = '0;
    chk("abort valid", 40'(acc_valid), 40'd0);
    chk("abort acc_out", acc_out, 40'd0);
    chk("abort ready", 40'(sample_ready), 40'd1);
    chk("abort busy", 40'(busy), 40'd0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (acc_valid) cnt++;
    end
    chk("abort no_pulse", 40'(cnt), 40'd0);
    run_pass(16'h0001, 1'b0, 40'd0, "post_reset_impulse");

    // clear coincident with accept
    do_reset();
    all_coef(16'h0001);
    for (int i = 0; i < NT; i++) begin
      run_pass(16'h0010, 1'b0, 40'(16 * (i + 1)), $sformatf("fill%0d", i));
    end
    run_pass(16'h0003, 1'b1, 40'd3, "clear_with_accept");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
